// File: rtl/adder_rr_sched.sv
// adder_rr_sched: round-robin scheduler sharing one carry-skip adder among
// NUM_REQ requesters, with results queued in a small registered FIFO.
//
// Ports:
//   i_clk, i_rst_n      clock (rising edge) and asynchronous active-low reset
//   i_req_valid         per-requester operand valid
//   i_req_a, i_req_b    operands, requester k at [k*WIDTH +: WIDTH]
//   o_req_ready         one-hot grant (zero when nothing is granted)
//   o_res_valid         FIFO head valid
//   o_res_sum/cout/id   FIFO head sum, carry-out and requester index
//   i_res_ready         consumer ready
//   o_fifo_level        current FIFO occupancy

// csa_11bit: 11-bit carry-skip adder built from 4/4/3-bit ripple blocks.
module csa_11bit (
    input  logic [10:0] a,
    input  logic [10:0] b,
    input  logic        cin,
    output logic [10:0] sum,
    output logic        cout
);
    logic [4:0] r0, r1;
    logic [3:0] r2;
    logic       c4, c8;
    // A block whose bits all propagate passes its carry-in straight through.
    always_comb begin
        r0   = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0, cin};
        c4   = (&(a[3:0] ^ b[3:0])) ? cin : r0[4];
        r1   = {1'b0, a[7:4]} + {1'b0, b[7:4]} + {4'b0, c4};
        c8   = (&(a[7:4] ^ b[7:4])) ? c4 : r1[4];
        r2   = {1'b0, a[10:8]} + {1'b0, b[10:8]} + {3'b0, c8};
        cout = (&(a[10:8] ^ b[10:8])) ? c8 : r2[3];
        sum  = {r2[2:0], r1[3:0], r0[3:0]};
    end
endmodule

module adder_rr_sched #(
    parameter int WIDTH      = 11,
    parameter int NUM_REQ    = 4,
    parameter int FIFO_DEPTH = 2,
    localparam int ID_W      = $clog2(NUM_REQ),
    localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [NUM_REQ-1:0]       i_req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] i_req_a,
    input  logic [NUM_REQ*WIDTH-1:0] i_req_b,
    output logic [NUM_REQ-1:0]       o_req_ready,
    output logic                     o_res_valid,
    output logic [WIDTH-1:0]         o_res_sum,
    output logic                     o_res_cout,
    output logic [ID_W-1:0]          o_res_id,
    input  logic                     i_res_ready,
    output logic [LVL_W-1:0]         o_fifo_level
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int E_W   = WIDTH + 1 + ID_W;

    logic [ID_W-1:0]  rr_ptr, win;
    logic             found, can_accept, push, pop;
    logic [WIDTH-1:0] add_a, add_b, add_sum;
    logic             add_cout;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [LVL_W-1:0] level;
    logic [E_W-1:0]   mem [FIFO_DEPTH];
    int               idx;

    // Search upward from the pointer with wrap; first valid requester wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_REQ;
            if (!found && i_req_valid[idx]) begin
                found = 1'b1;
                win   = ID_W'(idx);
            end
        end
    end

    // A full FIFO still accepts when its head leaves in the same cycle.
    assign can_accept  = (level < LVL_W'(FIFO_DEPTH)) | i_res_ready;
    assign push        = found & can_accept & i_rst_n;
    assign pop         = o_res_valid & i_res_ready;
    assign o_req_ready = push ? (NUM_REQ'(1) << win) : '0;

    assign add_a = push ? i_req_a[win*WIDTH +: WIDTH] : '0;
    assign add_b = push ? i_req_b[win*WIDTH +: WIDTH] : '0;

    csa_11bit u_add (
        .a    (add_a),
        .b    (add_b),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rr_ptr <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            rr_ptr <= push ? ((win == ID_W'(NUM_REQ - 1)) ? '0 : win + ID_W'(1)) : rr_ptr;
            wr_ptr <= push ? wr_ptr + PTR_W'(1) : wr_ptr;
            rd_ptr <= pop ? rd_ptr + PTR_W'(1) : rd_ptr;
            level  <= (push && !pop) ? level + LVL_W'(1) :
                      (pop && !push) ? level - LVL_W'(1) : level;
        end
    end

    // Storage needs no reset: outputs are masked whenever the FIFO is empty.
    always_ff @(posedge i_clk) begin
        if (push)
            mem[wr_ptr] <= {add_cout, add_sum, win};
    end

    assign o_res_valid  = (level != '0);
    assign o_fifo_level = level;
    assign {o_res_cout, o_res_sum, o_res_id} = o_res_valid ? mem[rd_ptr] : '0;
endmodule

// File: tb/tb_adder_rr_sched.sv
// tb_adder_rr_sched: randomized and directed checks of adder_rr_sched against a queue model.
module tb_adder_rr_sched;
    localparam int N = 4;
    localparam int W = 11;
    localparam int D = 2;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic [1:0]   id;
    } res_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   valid = '0;
    logic [W-1:0]   a_op [N];
    logic [W-1:0]   b_op [N];
    logic [N*W-1:0] req_a, req_b;
    logic [N-1:0]   ready;
    logic           res_valid, res_cout, res_ready = 1'b0;
    logic [W-1:0]   res_sum;
    logic [1:0]     res_id;
    logic [1:0]     level;

    res_t       q[$];
    int         mptr = 0;
    logic [N-1:0] last_grant = '0;
    int         vectors = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        req_a = '0;
        req_b = '0;
        for (int k = 0; k < N; k++) begin
            req_a[k*W +: W] = a_op[k];
            req_b[k*W +: W] = b_op[k];
        end
    end

    adder_rr_sched dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req_valid  (valid),
        .i_req_a      (req_a),
        .i_req_b      (req_b),
        .o_req_ready  (ready),
        .o_res_valid  (res_valid),
        .o_res_sum    (res_sum),
        .o_res_cout   (res_cout),
        .o_res_id     (res_id),
        .i_res_ready  (res_ready),
        .o_fifo_level (level)
    );

    function automatic logic [N-1:0] exp_grant();
        int j;
        if (!rst_n) return '0;
        if (!(q.size() < D || (q.size() == D && res_ready))) return '0;
        for (int i = 0; i < N; i++) begin
            j = (mptr + i) % N;
            if (valid[j]) return N'(1 << j);
        end
        return '0;
    endfunction

    // Advance one clock and apply the same accept/pop to the model.
    task automatic tick();
        logic [N-1:0] g;
        logic         p;
        res_t         r;
        g = exp_grant();
        p = (q.size() > 0) && res_ready && rst_n;
        @(posedge clk);
        if (p) void'(q.pop_front());
        for (int k = 0; k < N; k++)
            if (g[k]) begin
                {r.cout, r.sum} = {1'b0, a_op[k]} + {1'b0, b_op[k]};
                r.id = 2'(k);
                q.push_back(r);
                mptr = (k + 1) % N;
            end
        last_grant = g;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        valid = '0;
        res_ready = 1'b0;
        q.delete();
        mptr = 0;
        last_grant = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        res_ready = 1'b1;
        valid = 4'hF;
        for (int k = 0; k < N; k++) begin
            a_op[k] = 11'(k + 3);
            b_op[k] = 11'(k * 7);
        end
        @(negedge clk);
        #1;
        vectors++; if (ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b exp 0000", ready); end
        vectors++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", res_valid); end
        vectors++; if (level !== 2'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
        vectors++; if ({res_cout, res_sum, res_id} !== '0) begin errors++; $display("FAIL reset_data got %h/%b/%0d exp 0", res_sum, res_cout, res_id); end
        rst_n = 1'b1;
        #1;
        vectors++; if (ready !== 4'b0001) begin errors++; $display("FAIL first_grant got %b exp 0001", ready); end
        tick();
        #1;
        vectors++; if (res_valid !== 1'b1 || res_id !== 2'd0 || res_sum !== 11'd3) begin
            errors++; $display("FAIL first_result got v=%b id=%0d sum=%0d exp v=1 id=0 sum=3", res_valid, res_id, res_sum);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        res_ready = 1'b1;
        valid = 4'hF;
        for (int k = 0; k < N; k++) begin
            a_op[k] = 11'(k + 1);
            b_op[k] = 11'(10 * (k + 1));
        end
        for (int i = 0; i < 8; i++) begin
            #1;
            vectors++; if (ready !== 4'(1 << (i % 4))) begin errors++; $display("FAIL rr_grant[%0d] got %b exp %b", i, ready, 4'(1 << (i % 4))); end
            if (i > 0) begin
                vectors++;
                if (res_valid !== 1'b1 || res_sum !== 11'(11 * ((i - 1) % 4 + 1)) || res_id !== 2'((i - 1) % 4) || level !== 2'd1) begin
                    errors++;
                    $display("FAIL rr_result[%0d] got v=%b sum=%0d id=%0d lvl=%0d exp v=1 sum=%0d id=%0d lvl=1",
                             i, res_valid, res_sum, res_id, level, 11 * ((i - 1) % 4 + 1), (i - 1) % 4);
                end
            end
            tick();
        end
    endtask

    task automatic test_wrap_carry();
        do_reset();
        res_ready = 1'b1;
        valid = 4'b0100;
        a_op[2] = 11'd5;
        b_op[2] = 11'd6;
        #1;
        vectors++; if (ready !== 4'b0100) begin errors++; $display("FAIL wrap_pre_grant got %b exp 0100", ready); end
        tick();
        a_op[2] = 11'h7FF;
        b_op[2] = 11'h001;
        #1;
        vectors++; if (ready !== 4'b0100) begin errors++; $display("FAIL wrap_grant got %b exp 0100", ready); end
        tick();
        valid = '0;
        #1;
        vectors++; if (res_valid !== 1'b1 || res_sum !== 11'd0 || res_cout !== 1'b1 || res_id !== 2'd2) begin
            errors++; $display("FAIL wrap_result got v=%b sum=%h c=%b id=%0d exp v=1 sum=000 c=1 id=2", res_valid, res_sum, res_cout, res_id);
        end
        valid = 4'hF;
        #1;
        vectors++; if (ready !== 4'b1000) begin errors++; $display("FAIL wrap_ptr got %b exp 1000", ready); end
        tick();
    endtask

    task automatic test_backpressure();
        logic [W-1:0] head_sum;
        do_reset();
        valid = 4'hF;
        for (int k = 0; k < N; k++) begin
            a_op[k] = 11'($urandom);
            b_op[k] = 11'($urandom);
        end
        #1;
        vectors++; if (ready !== 4'b0001) begin errors++; $display("FAIL bp_grant0 got %b exp 0001", ready); end
        tick();
        #1;
        vectors++; if (ready !== 4'b0010) begin errors++; $display("FAIL bp_grant1 got %b exp 0010", ready); end
        tick();
        head_sum = a_op[0] + b_op[0];
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++; if (ready !== 4'b0000 || level !== 2'd2) begin errors++; $display("FAIL bp_full[%0d] got rdy=%b lvl=%0d exp rdy=0000 lvl=2", i, ready, level); end
            vectors++; if (res_id !== 2'd0 || res_sum !== head_sum) begin errors++; $display("FAIL bp_head[%0d] got id=%0d sum=%h exp id=0 sum=%h", i, res_id, res_sum, head_sum); end
            tick();
        end
        res_ready = 1'b1;
        #1;
        vectors++; if (ready !== 4'b0100) begin errors++; $display("FAIL bp_pass_grant got %b exp 0100", ready); end
        tick();
        #1;
        vectors++; if (level !== 2'd2 || res_id !== 2'd1) begin errors++; $display("FAIL bp_pass got lvl=%0d id=%0d exp lvl=2 id=1", level, res_id); end
    endtask

    task automatic test_async_reset();
        res_ready = 1'b0;
        valid = 4'hF;
        for (int i = 0; i < 4 && q.size() < D; i++) tick();
        #1;
        vectors++; if (level !== 2'd2) begin errors++; $display("FAIL ar_full got %0d exp 2", level); end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++; if (res_valid !== 1'b0 || level !== 2'd0 || ready !== 4'b0000) begin
            errors++; $display("FAIL ar_assert got v=%b lvl=%0d rdy=%b exp 0/0/0000", res_valid, level, ready);
        end
        vectors++; if ({res_cout, res_sum, res_id} !== '0) begin errors++; $display("FAIL ar_data got %h/%b/%0d exp 0", res_sum, res_cout, res_id); end
        q.delete();
        mptr = 0;
        last_grant = '0;
        @(negedge clk);
        valid = '0;
        res_ready = 1'b1;
        rst_n = 1'b1;
        #1;
        vectors++; if (res_valid !== 1'b0 || level !== 2'd0) begin errors++; $display("FAIL ar_release got v=%b lvl=%0d exp 0/0", res_valid, level); end
        tick();
        #1;
        vectors++; if (res_valid !== 1'b0) begin errors++; $display("FAIL ar_stale got %b exp 0", res_valid); end
        valid = 4'hF;
        #1;
        vectors++; if (ready !== 4'b0001) begin errors++; $display("FAIL ar_grant got %b exp 0001", ready); end
        tick();
    endtask

    task automatic test_skip();
        do_reset();
        res_ready = 1'b1;
        valid = 4'b0001;
        #1;
        tick();
        valid = 4'b1000;
        #1;
        vectors++; if (ready !== 4'b1000) begin errors++; $display("FAIL skip_grant got %b exp 1000", ready); end
        tick();
        valid = 4'hF;
        #1;
        vectors++; if (ready !== 4'b0001) begin errors++; $display("FAIL skip_ptr got %b exp 0001", ready); end
        tick();
    endtask

    task automatic test_random();
        logic [N-1:0] eg;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < N; k++)
                if (!valid[k] || last_grant[k]) begin
                    valid[k] = ($urandom_range(0, 2) != 0);
                    a_op[k] = 11'($urandom);
                    b_op[k] = 11'($urandom);
                end
            res_ready = ($urandom_range(0, 3) != 0);
            #1;
            eg = exp_grant();
            vectors++; if (ready !== eg) begin errors++; $display("FAIL rnd_grant[%0d] got %b exp %b", i, ready, eg); end
            vectors++; if (res_valid !== (q.size() != 0) || level !== 2'(q.size())) begin
                errors++; $display("FAIL rnd_state[%0d] got v=%b lvl=%0d exp lvl=%0d", i, res_valid, level, q.size());
            end
            if (q.size() != 0) begin
                vectors++; if ({res_sum, res_cout, res_id} !== q[0]) begin
                    errors++; $display("FAIL rnd_head[%0d] got sum=%h c=%b id=%0d exp sum=%h c=%b id=%0d",
                                       i, res_sum, res_cout, res_id, q[0].sum, q[0].cout, q[0].id);
                end
            end
            tick();
        end
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            a_op[k] = '0;
            b_op[k] = '0;
        end
        test_reset();
        test_round_robin();
        test_wrap_carry();
        test_backpressure();
        test_async_reset();
        test_skip();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
